// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_WAIT  = 2'd1,
    MS_FAULT = 2'd2
  } mem_state_t;

  localparam int unsigned CNT_MAX_W = 64;

  // Saturating increment for counters up to CNT_MAX_W bits wide; w is the live width.
  function automatic logic [CNT_MAX_W-1:0] cnt_next(input logic [CNT_MAX_W-1:0] cnt,
                                                    input logic inc,
                                                    input int unsigned w);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = (w >= CNT_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    if (inc && (cnt != max_v)) cnt_next = cnt + 64'd1;
    else                       cnt_next = cnt;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait-state tracker: stalls M while memory is busy, latches a
// sticky fault when one access waits past MEM_TIMEOUT cycles.
//
// state    | meaning
// MS_IDLE  | no access outstanding, or a zero-wait access completing
// MS_WAIT  | access held in M, counting wait cycles
// MS_FAULT | timeout seen; pipeline frozen until reset
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic MemReqM,
  input  logic MemReadyM,
  output logic mem_stall,
  output logic mem_fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_d   = MS_WAIT;
          cnt_d     = CW'(1);
          mem_stall = 1'b1;
        end
      end
      MS_WAIT: begin
        if (MemReadyM) begin
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (cnt_q == CW'(MEM_TIMEOUT)) state_d = MS_FAULT;
          else                           cnt_d   = cnt_q + CW'(1);
        end
      end
      MS_FAULT: mem_stall = 1'b1;
      default:  state_d   = MS_IDLE;
    endcase
  end

  assign mem_fault = (state_q == MS_FAULT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush generation and
// memory wait handling. Define HAZARD_PERF_EN to build the performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Match_1E_M,
  input  logic             Match_1E_W,
  input  logic             Match_2E_M,
  input  logic             Match_2E_W,
  input  logic             Match_12D_E,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemFault,
  output logic [CNT_W-1:0] LdUseCnt,
  output logic [CNT_W-1:0] MemWaitCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic ld_use, mem_stall, mem_fault;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk       (clk),
    .reset     (reset),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .mem_stall (mem_stall),
    .mem_fault (mem_fault)
  );

  assign ld_use = Match_12D_E & MemtoRegE;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemFault  = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (Match_1E_M && RegWriteM)      ForwardAE = FWD_M;
      else if (Match_1E_W && RegWriteW) ForwardAE = FWD_W;
      if (Match_2E_M && RegWriteM)      ForwardBE = FWD_M;
      else if (Match_2E_W && RegWriteW) ForwardBE = FWD_W;
      MemFault = mem_fault;
      // A memory stall freezes everything upstream of W; branch and load-use
      // flushes wait until release so the held instructions survive.
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ld_use | PCWrPendingF;
        StallD = ld_use;
        FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
        FlushE = ld_use | BranchTakenE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] ld_use_cnt_q, mem_wait_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_use_cnt_q   <= '0;
      mem_wait_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ld_use_cnt_q   <= CNT_W'(cnt_next(CNT_MAX_W'(ld_use_cnt_q), ld_use & ~mem_stall, CNT_W));
      mem_wait_cnt_q <= CNT_W'(cnt_next(CNT_MAX_W'(mem_wait_cnt_q), mem_stall, CNT_W));
      flush_cnt_q    <= CNT_W'(cnt_next(CNT_MAX_W'(flush_cnt_q), FlushD & ~mem_stall, CNT_W));
    end
  end

  assign LdUseCnt   = ld_use_cnt_q;
  assign MemWaitCnt = mem_wait_cnt_q;
  assign FlushCnt   = flush_cnt_q;
`else
  assign LdUseCnt   = '0;
  assign MemWaitCnt = '0;
  assign FlushCnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational paths,
// hand sequences for memory wait, timeout fault and reset.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE;
  logic MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
  logic [CNT_W-1:0] LdUseCnt, MemWaitCnt, FlushCnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemFault(MemFault),
    .LdUseCnt(LdUseCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt)
  );

  int n_cmp = 0;
  int n_err = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Input order: m1m, m1w, m2m, m2w, m12, rwm, rww, mtr, pcwp, pcsw, bte
  typedef struct packed {
    logic [10:0] in;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [10:0] mk_in(input logic m1m, m1w, m2m, m2w, m12, rwm, rww,
                                        mtr, pcwp, pcsw, bte);
    return {m1m, m1w, m2m, m2w, m12, rwm, rww, mtr, pcwp, pcsw, bte};
  endfunction

  // Output order: ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault
  function automatic logic [11:0] mk_exp(input logic [1:0] fa, fb, input logic sf, sd, se, sm,
                                         fd, fe, fw, mf);
    return {fa, fb, sf, sd, se, sm, fd, fe, fw, mf};
  endfunction

  task automatic set_in(input logic [10:0] v);
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E, RegWriteM, RegWriteW,
     MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE} = v;
  endtask

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b (fa fb sf sd se sm fd fe fw mf)", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in('0);
    MemReqM   = 1'b0;
    MemReadyM = 1'b0;
    reset     = 1'b1;
    next_cyc();
    reset     = 1'b0;
  endtask

  logic [11:0] idle_v, stall_all, fault_v, reset_v;

  initial begin
    idle_v    = mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    stall_all = mk_exp(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0);
    fault_v   = mk_exp(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 1);
    reset_v   = mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1, 0);

    vecs[0]  = {mk_in(0,0,0,0,0,0,0,0,0,0,0), mk_exp(2'b00,2'b00,0,0,0,0,0,0,0,0)};
    vecs[1]  = {mk_in(1,1,0,0,0,1,1,0,0,0,0), mk_exp(2'b10,2'b00,0,0,0,0,0,0,0,0)};
    vecs[2]  = {mk_in(1,1,0,0,0,0,1,0,0,0,0), mk_exp(2'b01,2'b00,0,0,0,0,0,0,0,0)};
    vecs[3]  = {mk_in(0,0,1,1,0,1,1,0,0,0,0), mk_exp(2'b00,2'b10,0,0,0,0,0,0,0,0)};
    vecs[4]  = {mk_in(0,0,1,1,0,0,1,0,0,0,0), mk_exp(2'b00,2'b01,0,0,0,0,0,0,0,0)};
    vecs[5]  = {mk_in(1,1,1,1,0,0,0,0,0,0,0), mk_exp(2'b00,2'b00,0,0,0,0,0,0,0,0)};
    vecs[6]  = {mk_in(1,0,0,1,0,1,1,0,0,0,0), mk_exp(2'b10,2'b01,0,0,0,0,0,0,0,0)};
    vecs[7]  = {mk_in(0,0,0,0,1,0,0,1,0,0,0), mk_exp(2'b00,2'b00,1,1,0,0,0,1,0,0)};
    vecs[8]  = {mk_in(0,0,0,0,1,0,0,0,0,0,0), mk_exp(2'b00,2'b00,0,0,0,0,0,0,0,0)};
    vecs[9]  = {mk_in(0,0,0,0,0,0,0,0,1,0,0), mk_exp(2'b00,2'b00,1,0,0,0,1,0,0,0)};
    vecs[10] = {mk_in(0,0,0,0,0,0,0,0,0,1,0), mk_exp(2'b00,2'b00,0,0,0,0,1,0,0,0)};
    vecs[11] = {mk_in(0,0,0,0,0,0,0,0,0,0,1), mk_exp(2'b00,2'b00,0,0,0,0,1,1,0,0)};
    vecs[12] = {mk_in(0,0,0,0,1,0,0,1,1,0,1), mk_exp(2'b00,2'b00,1,1,0,0,1,1,0,0)};
    vecs[13] = {mk_in(0,1,0,0,0,1,0,0,0,0,0), mk_exp(2'b00,2'b00,0,0,0,0,0,0,0,0)};

    // Reset state with forwarding conditions present: everything must stay quiet.
    set_in(mk_in(1,1,1,1,1,1,1,1,1,1,1));
    MemReqM = 1'b1; MemReadyM = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs", reset_v);
    next_cyc();
    reset = 1'b0;
    set_in('0); MemReqM = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", idle_v);
    chk_cnt("after_reset_memwait", MemWaitCnt, '0);

    foreach (vecs[i]) begin
      set_in(vecs[i].in);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].exp);
      next_cyc();
    end

    // Single load-use cycle.
    do_reset();
    set_in(mk_in(0,0,0,0,1,0,0,1,0,0,0));
    @(negedge clk);
    chk("lduse_cycle", mk_exp(2'b00,2'b00,1,1,0,0,0,1,0,0));
    next_cyc();
    set_in('0);
    @(negedge clk);
    chk("lduse_after", idle_v);
    chk_cnt("lduse_cnt", LdUseCnt, PERF ? CNT_W'(1) : '0);
    chk_cnt("lduse_flushcnt", FlushCnt, '0);

    // Three wait cycles, with a load-use pending the whole time.
    do_reset();
    set_in(mk_in(0,0,0,0,1,0,0,1,0,0,0));
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("wait3_stall%0d", k), stall_all);
      next_cyc();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    chk("wait3_release", mk_exp(2'b00,2'b00,1,1,0,0,0,1,0,0));
    next_cyc();
    set_in('0); MemReqM = 1'b0; MemReadyM = 1'b0;
    @(negedge clk);
    chk("wait3_idle", idle_v);
    chk_cnt("wait3_memwaitcnt", MemWaitCnt, PERF ? CNT_W'(3) : '0);

    // Zero-wait access never stalls.
    MemReqM = 1'b1; MemReadyM = 1'b1;
    @(negedge clk);
    chk("zero_wait", idle_v);
    next_cyc();
    MemReqM = 1'b0; MemReadyM = 1'b0;

    // Branch taken during a wait is held off until release.
    do_reset();
    set_in(mk_in(0,0,0,0,0,0,0,0,0,0,1));
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("br_wait%0d", k), stall_all);
      next_cyc();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    chk("br_release", mk_exp(2'b00,2'b00,0,0,0,0,1,1,0,0));
    next_cyc();
    MemReqM = 1'b0; MemReadyM = 1'b0; set_in('0);

    // Timeout: 1 IDLE cycle + MEM_TIMEOUT WAIT cycles of not-ready, then FAULT.
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= MEM_TIMEOUT + 1; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", k), stall_all);
      next_cyc();
    end
    @(negedge clk);
    chk("to_fault", fault_v);
    next_cyc();
    MemReqM = 1'b0; MemReadyM = 1'b1;
    @(negedge clk);
    chk("to_fault_sticky", fault_v);
    next_cyc();
    set_in(mk_in(1,1,1,1,0,1,1,0,0,0,0));
    reset = 1'b1;
    @(negedge clk);
    chk("to_in_reset", reset_v);
    next_cyc();
    reset = 1'b0; set_in('0); MemReadyM = 1'b0;
    @(negedge clk);
    chk("to_cleared", idle_v);
    next_cyc();

    // Reset in the middle of a wait.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("midw_wait%0d", k), stall_all);
      next_cyc();
    end
    reset = 1'b1;
    next_cyc();
    reset = 1'b0; MemReqM = 1'b0;
    @(negedge clk);
    chk("midw_after_reset", idle_v);
    chk_cnt("midw_memwaitcnt", MemWaitCnt, '0);
    chk_cnt("midw_ldusecnt", LdUseCnt, '0);
    chk_cnt("midw_flushcnt", FlushCnt, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage ARM core. It sits beside the datapath and consumes its register-match flags and the controller's stage-valid signals. It drives the forwarding selects, the stage stalls/flushes and a wait-state handshake with data memory. The memory path adds a state machine with a timeout fault. An optional set of hazard performance counters can be compiled in.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles tolerated for one data-memory access before fault (≥1)
- CNT_W, 32: width of performance counters
- clk  in  1  core clock; one clock; all state on rising edge
- reset  in  1  synchronous, active-high
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1 each  source-register match flags from datapath
- Match_12D_E  in  1  Decode source matches Execute destination
- RegWriteM, RegWriteW  in  1  destination write enables in M / W
- MemtoRegE  in  1  instruction in E is a load
- PCWrPendingF  in  1  PC write in flight in D, E or M
- PCSrcW, BranchTakenE  in  1  PC redirect from W / taken branch in E
- MemReqM  in  1  instruction in M accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  bypass selects: 00 register file, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  clear stage register to bubble
- MemFault  out  1  sticky memory-timeout fault
- LdUseCnt, MemWaitCnt, FlushCnt  out  CNT_W  performance counters (see Configuration)

## Operation
- Forwarding, per operand: 10 if Match_xE_M & RegWriteM, else 01 if Match_xE_W & RegWriteW, else 00. M beats W.
- LdUse = Match_12D_E & MemtoRegE.
- MemStall = (state IDLE & MemReqM & ~MemReadyM) | (state WAIT & ~MemReadyM) | state FAULT.
- Memory FSM states: IDLE, WAIT, FAULT.
  - IDLE→WAIT on MemReqM & ~MemReadyM; wait counter loads 1.
  - In WAIT with MemReadyM: go to IDLE. With ~MemReadyM: counter+1.
  - WAIT→FAULT when counter == MEM_TIMEOUT & ~MemReadyM.
  - FAULT holds until reset.
  - A zero-wait access (MemReqM & MemReadyM in IDLE) causes no stall.
- MemStall=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1 (bubble into W).
  - FlushD=FlushE=0, because held state must not be destroyed. Branch and load-use are re-evaluated after release.
- MemStall=0:
  - StallF = LdUse | PCWrPendingF; StallD = LdUse; StallE=StallM=0.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LdUse | BranchTakenE; FlushW=0.
- MemFault = (state == FAULT).

## Timing
- Forward, stall and flush outputs are combinational from inputs and current state, with no added latency. Only FSM state and counters are registered.
- Stall release: the cycle MemReadyM=1 is seen in WAIT, all MemStall-driven outputs are 0 in that same cycle. The held M access completes on that edge.
- Wait of N cycles (MemReadyM low N cycles, then high) gives exactly N stalled cycles, for N ≤ MEM_TIMEOUT.
- Fault: MemReadyM low for MEM_TIMEOUT cycles after WAIT entry gives FAULT at the next edge. Stalls and MemFault stay 1 until reset.
- While reset=1:
  - Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00, MemFault=0.
  - Next state is IDLE and counters clear, with priority over every other event, including mid-WAIT or FAULT.
- Simultaneous MemReqM and LdUse: MemStall dominates, and LdUse resolves after release.

## Configuration
- HAZARD_PERF_EN defined: three saturating CNT_W counters, each +1 per cycle (outside reset):
  - LdUseCnt counts cycles with LdUse & ~MemStall.
  - MemWaitCnt counts cycles with MemStall.
  - FlushCnt counts cycles with FlushD & ~MemStall.
  - At all-ones a counter holds.
- HAZARD_PERF_EN undefined: no counter flops; outputs tied to 0.

## Structure
- Package hazard_pkg:
  - fwd_sel_t (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - mem_state_t (MS_IDLE, MS_WAIT, MS_FAULT).
  - Counter increment/saturation helper.
- Sub-module mem_wait_fsm holds the state register, wait counter ($clog2(MEM_TIMEOUT+1) bits) and MemStall/MemFault generation.
- Top-level hazard_ctrl holds the forwarding, stall/flush combine and optional counters.

## Test plan
- Match_1E_M=1, RegWriteM=1, Match_1E_W=1, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Same checks on the B operand.
- Match_12D_E=1, MemtoRegE=1, MemReqM=0 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. With HAZARD_PERF_EN, LdUseCnt=1.
- MemReqM=1, MemReadyM low 3 cycles then high -> Stall F/D/E/M and FlushW high exactly 3 cycles, all 0 on the ready cycle, MemWaitCnt=3.
- MemReqM=1 with MEM_TIMEOUT=4 and MemReadyM held 0 -> MemFault=1 after cycle 4. Stays 1 with MemReadyM later 1. Reset clears it to 0 and the FSM to IDLE.
- BranchTakenE=1 during WAIT -> FlushD=FlushE=0. After release with BranchTakenE still 1 -> FlushD=FlushE=1.
- Reset asserted mid-WAIT -> next cycle, with MemReqM=0: all stalls 0, MemFault 0, counters 0.
